// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO constants and Gray/binary helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_ADDRSIZE_DEFAULT = 4;
    // Helpers work at a fixed maximum width; callers cast in and slice out.
    localparam int c_PTR_MAX = 32;

    function automatic logic [c_PTR_MAX-1:0] bin2gray(input logic [c_PTR_MAX-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [c_PTR_MAX-1:0] gray2bin(input logic [c_PTR_MAX-1:0] gray);
        logic [c_PTR_MAX-1:0] bin;
        bin[c_PTR_MAX-1] = gray[c_PTR_MAX-1];
        for (int i = c_PTR_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rptr_empty_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_prog_if
// Description : Read-side request/status bundle of the async FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface rptr_empty_prog_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = c_ADDRSIZE_DEFAULT
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE:0]   ae_thresh;
    logic                uflow_clr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rcount;
    logic                rvalid;
    logic                ruflow;

    modport master (
        output rinc, rq2_wptr, ae_thresh, uflow_clr,
        input  raddr, rptr, rempty, raempty, rcount, rvalid, ruflow
    );

    modport slave (
        input  rinc, rq2_wptr, ae_thresh, uflow_clr,
        output raddr, rptr, rempty, raempty, rcount, rvalid, ruflow
    );
endinterface
`default_nettype wire

// File: rtl/rptr_empty_prog_gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary converter (XOR prefix).
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  wire logic [WIDTH-1:0] i_gray,
    output logic      [WIDTH-1:0] o_bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end
endmodule
`default_nettype wire

// File: rtl/rptr_empty_prog.sv
`default_nettype none
// ============================================================================
// Module      : rptr_empty_prog
// Description : Read pointer, empty/almost-empty, fill level, rvalid, underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_prog
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = c_ADDRSIZE_DEFAULT
) (
    input  wire logic        rclk,
    input  wire logic        rrst_n,
    rptr_empty_prog_if.slave bus
);
    localparam int c_PW = ADDRSIZE + 1;

    logic [c_PW-1:0] r_rbin;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW-1:0] r_rcount;
    logic            r_rempty;
    logic            r_raempty;
    logic            r_rvalid;
    logic            r_ruflow;

    logic            w_racc;
    logic [c_PW-1:0] w_rbinnext;
    logic [c_PW-1:0] w_rgraynext;
    logic [c_PW-1:0] w_wbin_s;
    logic [c_PW-1:0] w_cnt_next;

    assign w_racc      = bus.rinc & ~r_rempty;
    assign w_rbinnext  = r_rbin + c_PW'(w_racc);
    assign w_rgraynext = c_PW'(bin2gray(c_PTR_MAX'(w_rbinnext)));
    // Modular difference keeps the level right across the pointer MSB wrap.
    assign w_cnt_next  = w_wbin_s - w_rbinnext;

    gray2bin #(
        .WIDTH (c_PW)
    ) u_wptr_g2b (
        .i_gray (bus.rq2_wptr),
        .o_bin  (w_wbin_s)
    );

    always_ff @(posedge rclk) begin
        if (!rrst_n) r_rbin <= '0;
        else         r_rbin <= w_rbinnext;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) r_rptr <= '0;
        else         r_rptr <= w_rgraynext;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) r_rcount <= '0;
        else         r_rcount <= w_cnt_next;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) r_rempty <= 1'b1;
        else         r_rempty <= (w_rgraynext == bus.rq2_wptr);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) r_raempty <= 1'b1;
        else         r_raempty <= (w_cnt_next <= bus.ae_thresh);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) r_rvalid <= 1'b0;
        else         r_rvalid <= w_racc;
    end

    // A new underflow event takes priority over a simultaneous clear.
    always_ff @(posedge rclk) begin
        if (!rrst_n)                       r_ruflow <= 1'b0;
        else if (bus.rinc && r_rempty)     r_ruflow <= 1'b1;
        else if (bus.uflow_clr)            r_ruflow <= 1'b0;
    end

    assign bus.raddr   = r_rbin[ADDRSIZE-1:0];
    assign bus.rptr    = r_rptr;
    assign bus.rcount  = r_rcount;
    assign bus.rempty  = r_rempty;
    assign bus.raempty = r_raempty;
    assign bus.rvalid  = r_rvalid;
    assign bus.ruflow  = r_ruflow;

endmodule
`default_nettype wire
